// File: rtl/trx_req_queue.sv
// trx_req_queue: AW/AR request FIFOs, DRAM burst chunking, write-beat
// credit gating and read/write arbitration for the RPC DRAM controller.
// Ports:
//   clk_i, rst_i                 clock, async active-high reset
//   aw_*_i / aw_ready_o          write request channel (byte addr, beats-1)
//   ar_*_i / ar_ready_o          read request channel (byte addr, beats-1)
//   w_push_i / w_credit_o        write beats entering SRAM / unreserved beats
//   aw_usage_o, ar_usage_o       address FIFO fill levels
//   trx_*                        one registered transaction to the command FSM

module trx_req_fifo #(
    parameter int Width = 8,
    parameter int Depth = 4,
    localparam int PtrW = $clog2(Depth),
    localparam int UsageW = PtrW + 1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              push_i,
    input  logic [Width-1:0]  data_i,
    input  logic              pop_i,
    output logic [Width-1:0]  data_o,
    output logic              empty_o,
    output logic              full_o,
    output logic [UsageW-1:0] usage_o
);
    logic [Width-1:0]  mem_q [Depth];
    logic [PtrW-1:0]   wr_q, wr_d;
    logic [PtrW-1:0]   rd_q, rd_d;
    logic [UsageW-1:0] cnt_q, cnt_d;

    always_comb begin
        wr_d  = wr_q;
        rd_d  = rd_q;
        cnt_d = cnt_q;
        if (push_i) wr_d = wr_q + PtrW'(1);
        if (pop_i)  rd_d = rd_q + PtrW'(1);
        if (push_i && !pop_i)      cnt_d = cnt_q + UsageW'(1);
        else if (!push_i && pop_i) cnt_d = cnt_q - UsageW'(1);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

    // Storage needs no reset: the counters define which entries are live.
    always_ff @(posedge clk_i) begin
        if (push_i) mem_q[wr_q] <= data_i;
    end

    assign data_o  = mem_q[rd_q];
    assign empty_o = (cnt_q == '0);
    assign full_o  = (cnt_q == UsageW'(Depth));
    assign usage_o = cnt_q;
endmodule

module trx_req_queue #(
    parameter int AxiAddrWidth  = 48,
    parameter int AxiLenWidth   = 8,
    parameter int DramAddrWidth = 20,
    parameter int DramLenWidth  = 6,
    parameter int DramDataWidth = 256,
    parameter int BufferDepth   = 4,
    parameter int DataBufBeats  = BufferDepth << DramLenWidth,
    parameter int ArbMode       = 0,
    parameter int StarveLimit   = 4,
    localparam int CreditW = $clog2(DataBufBeats) + 1,
    localparam int UsageW  = $clog2(BufferDepth) + 1
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic [AxiAddrWidth-1:0]  aw_addr_i,
    input  logic [AxiLenWidth-1:0]   aw_len_i,
    input  logic                     aw_valid_i,
    output logic                     aw_ready_o,
    input  logic [AxiAddrWidth-1:0]  ar_addr_i,
    input  logic [AxiLenWidth-1:0]   ar_len_i,
    input  logic                     ar_valid_i,
    output logic                     ar_ready_o,
    input  logic                     w_push_i,
    output logic [CreditW-1:0]       w_credit_o,
    output logic [UsageW-1:0]        aw_usage_o,
    output logic [UsageW-1:0]        ar_usage_o,
    output logic                     trx_valid_o,
    input  logic                     trx_ready_i,
    output logic                     trx_is_write_o,
    output logic [DramAddrWidth-1:0] trx_addr_o,
    output logic [DramLenWidth-1:0]  trx_len_o
);
    localparam int AlignPos = $clog2(DramDataWidth / 8);
    localparam int MaxBeats = 2 ** DramLenWidth;
    localparam int RemW     = AxiLenWidth + 1;
    localparam int BW       = (RemW > DramLenWidth + 1) ? RemW : DramLenWidth + 1;
    localparam int EntW     = DramAddrWidth + RemW;
    localparam int StW      = (StarveLimit > 0) ? $clog2(StarveLimit + 1) : 1;
    localparam logic [CreditW-1:0] CreditMax = CreditW'(DataBufBeats);

    typedef enum logic {IDLE, ISSUE} state_e;

    state_e                   state_q, state_d;
    logic [DramAddrWidth-1:0] addr_q, addr_d;
    logic [RemW-1:0]          rem_q, rem_d;
    logic [DramLenWidth-1:0]  len_q, len_d;
    logic                     wr_q, wr_d;
    logic [CreditW-1:0]       credit_q, credit_d;
    logic                     prefer_w_q, prefer_w_d;
    logic [StW-1:0]           starve_q, starve_d;

    logic [EntW-1:0] aw_ent, ar_ent, aw_head, ar_head, sel;
    logic            aw_empty, ar_empty, aw_full, ar_full;
    logic            aw_push, ar_push, aw_pop, ar_pop;
    logic            grant_w, hs, in_issue;
    logic [BW-1:0]   cb;

    // Chunk length for a given remaining beat count: min(rem, MaxBeats)-1.
    function automatic logic [DramLenWidth-1:0] chunk_len(
        input logic [RemW-1:0] beats
    );
        logic [BW-1:0] b;
        b = BW'(beats);
        if (b >= BW'(MaxBeats)) chunk_len = '1;
        else                    chunk_len = DramLenWidth'(b - BW'(1));
    endfunction

    assign aw_ent = {aw_addr_i[AlignPos +: DramAddrWidth],
                     RemW'(aw_len_i) + RemW'(1)};
    assign ar_ent = {ar_addr_i[AlignPos +: DramAddrWidth],
                     RemW'(ar_len_i) + RemW'(1)};

    // A pop from IDLE frees a slot in the same cycle, so a full FIFO
    // may still take a push then; pop depends only on registered state.
    assign aw_ready_o = !aw_full || aw_pop;
    assign ar_ready_o = !ar_full || ar_pop;
    assign aw_push    = aw_valid_i && aw_ready_o;
    assign ar_push    = ar_valid_i && ar_ready_o;

    trx_req_fifo #(.Width(EntW), .Depth(BufferDepth)) u_aw_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (aw_push),
        .data_i  (aw_ent),
        .pop_i   (aw_pop),
        .data_o  (aw_head),
        .empty_o (aw_empty),
        .full_o  (aw_full),
        .usage_o (aw_usage_o)
    );

    trx_req_fifo #(.Width(EntW), .Depth(BufferDepth)) u_ar_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (ar_push),
        .data_i  (ar_ent),
        .pop_i   (ar_pop),
        .data_o  (ar_head),
        .empty_o (ar_empty),
        .full_o  (ar_full),
        .usage_o (ar_usage_o)
    );

    assign in_issue    = (state_q == ISSUE);
    assign cb          = BW'(len_q) + BW'(1);
    assign trx_valid_o = in_issue && (!wr_q || credit_q >= CreditW'(cb));
    assign hs          = trx_valid_o && trx_ready_i;

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        rem_d      = rem_q;
        len_d      = len_q;
        wr_d       = wr_q;
        prefer_w_d = prefer_w_q;
        starve_d   = starve_q;
        aw_pop     = 1'b0;
        ar_pop     = 1'b0;
        grant_w    = 1'b0;
        sel        = '0;
        unique case (state_q)
            IDLE: begin
                if (!aw_empty || !ar_empty) begin
                    if (!aw_empty && !ar_empty) begin
                        if (ArbMode == 0) grant_w = prefer_w_q;
                        else grant_w = (starve_q == StW'(StarveLimit));
                    end else begin
                        grant_w = !aw_empty;
                    end
                    aw_pop     = grant_w;
                    ar_pop     = !grant_w;
                    sel        = grant_w ? aw_head : ar_head;
                    addr_d     = sel[EntW-1 -: DramAddrWidth];
                    rem_d      = sel[RemW-1:0];
                    len_d      = chunk_len(sel[RemW-1:0]);
                    wr_d       = grant_w;
                    prefer_w_d = !grant_w;
                    if (grant_w)        starve_d = '0;
                    else if (!aw_empty) starve_d = starve_q + StW'(1);
                    state_d    = ISSUE;
                end
            end
            ISSUE: begin
                if (hs) begin
                    if (BW'(rem_q) > cb) begin
                        rem_d  = RemW'(BW'(rem_q) - cb);
                        addr_d = addr_q + DramAddrWidth'(MaxBeats);
                        len_d  = chunk_len(RemW'(BW'(rem_q) - cb));
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        credit_d = credit_q;
        if (w_push_i)   credit_d = credit_d + CreditW'(1);
        if (hs && wr_q) credit_d = credit_d - CreditW'(cb);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            rem_q      <= '0;
            len_q      <= '0;
            wr_q       <= 1'b0;
            credit_q   <= '0;
            prefer_w_q <= 1'b1;
            starve_q   <= '0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            rem_q      <= rem_d;
            len_q      <= len_d;
            wr_q       <= wr_d;
            credit_q   <= credit_d;
            prefer_w_q <= prefer_w_d;
            starve_q   <= starve_d;
        end
    end

    assign w_credit_o     = credit_q;
    assign trx_is_write_o = in_issue && wr_q;
    assign trx_addr_o     = in_issue ? addr_q : '0;
    assign trx_len_o      = in_issue ? len_q : '0;

    // Upstream must never push a beat into a full write-data SRAM.
    a_credit_overflow: assert property (
        @(posedge clk_i) disable iff (rst_i)
        !(w_push_i && credit_q == CreditMax)
    );
endmodule

// File: tb/tb_trx_req_queue.sv
// tb_trx_req_queue: directed stimulus with a scoreboard of expected
// transactions checked by per-DUT monitors on every trx handshake.

module tb_trx_req_queue;
    typedef struct packed {
        logic        w;
        logic [19:0] a;
        logic [5:0]  l;
    } trx_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    trx_t exp0[$];
    trx_t exp1[$];

    // DUT 0: round-robin
    logic [47:0] aw_addr, ar_addr;
    logic [7:0]  aw_len, ar_len;
    logic        aw_valid, ar_valid, w_push, trx_ready;
    logic        aw_ready, ar_ready, tv, tw;
    logic [8:0]  credit;
    logic [2:0]  aw_use, ar_use;
    logic [19:0] ta;
    logic [5:0]  tl;

    // DUT 1: read priority, starvation limit 2
    logic [47:0] b_aw_addr, b_ar_addr;
    logic [7:0]  b_aw_len, b_ar_len;
    logic        b_aw_valid, b_ar_valid, b_w_push, b_trx_ready;
    logic        b_aw_ready, b_ar_ready, b_tv, b_tw;
    logic [8:0]  b_credit;
    logic [2:0]  b_aw_use, b_ar_use;
    logic [19:0] b_ta;
    logic [5:0]  b_tl;

    trx_req_queue dut0 (
        .clk_i(clk), .rst_i(rst),
        .aw_addr_i(aw_addr), .aw_len_i(aw_len),
        .aw_valid_i(aw_valid), .aw_ready_o(aw_ready),
        .ar_addr_i(ar_addr), .ar_len_i(ar_len),
        .ar_valid_i(ar_valid), .ar_ready_o(ar_ready),
        .w_push_i(w_push), .w_credit_o(credit),
        .aw_usage_o(aw_use), .ar_usage_o(ar_use),
        .trx_valid_o(tv), .trx_ready_i(trx_ready),
        .trx_is_write_o(tw), .trx_addr_o(ta), .trx_len_o(tl)
    );

    trx_req_queue #(.ArbMode(1), .StarveLimit(2)) dut1 (
        .clk_i(clk), .rst_i(rst),
        .aw_addr_i(b_aw_addr), .aw_len_i(b_aw_len),
        .aw_valid_i(b_aw_valid), .aw_ready_o(b_aw_ready),
        .ar_addr_i(b_ar_addr), .ar_len_i(b_ar_len),
        .ar_valid_i(b_ar_valid), .ar_ready_o(b_ar_ready),
        .w_push_i(b_w_push), .w_credit_o(b_credit),
        .aw_usage_o(b_aw_use), .ar_usage_o(b_ar_use),
        .trx_valid_o(b_tv), .trx_ready_i(b_trx_ready),
        .trx_is_write_o(b_tw), .trx_addr_o(b_ta), .trx_len_o(b_tl)
    );

    task automatic chk(string n, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", n, act, exp);
        end
    endtask

    function automatic trx_t mk(logic w, logic [19:0] a, logic [5:0] l);
        trx_t t;
        t.w = w;
        t.a = a;
        t.l = l;
        return t;
    endfunction

    always @(negedge clk) begin
        if (!rst && tv && trx_ready) begin
            if (exp0.size() == 0) begin
                chk("dut0 unexpected trx", {tw, ta, tl}, '1);
            end else begin
                chk("dut0 trx", {tw, ta, tl}, exp0.pop_front());
            end
        end
        if (!rst && b_tv && b_trx_ready) begin
            if (exp1.size() == 0) begin
                chk("dut1 unexpected trx", {b_tw, b_ta, b_tl}, '1);
            end else begin
                chk("dut1 trx", {b_tw, b_ta, b_tl}, exp1.pop_front());
            end
        end
    end

    task automatic cyc(int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clr_inputs();
        aw_addr = '0; aw_len = '0; aw_valid = 0;
        ar_addr = '0; ar_len = '0; ar_valid = 0;
        w_push = 0; trx_ready = 0;
        b_aw_addr = '0; b_aw_len = '0; b_aw_valid = 0;
        b_ar_addr = '0; b_ar_len = '0; b_ar_valid = 0;
        b_w_push = 0; b_trx_ready = 0;
    endtask

    task automatic do_reset();
        rst = 1;
        clr_inputs();
        cyc(2);
        rst = 0;
    endtask

    task automatic drain0(int lim);
        int n = 0;
        while (exp0.size() != 0 && n < lim) begin
            cyc();
            n++;
        end
        chk("dut0 drained in time", exp0.size(), 0);
    endtask

    task automatic drain1(int lim);
        int n = 0;
        while (exp1.size() != 0 && n < lim) begin
            cyc();
            n++;
        end
        chk("dut1 drained in time", exp1.size(), 0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        clr_inputs();
        rst = 1;
        cyc(2);
        @(negedge clk);
        chk("rst valid", tv, 0);
        chk("rst aw_ready", aw_ready, 1);
        chk("rst ar_ready", ar_ready, 1);
        chk("rst credit", credit, 0);
        chk("rst usage", {aw_use, ar_use}, 0);
        chk("rst trx fields", {tw, ta, tl}, 0);
        chk("rst dut1 valid/ready", {b_tv, b_aw_ready, b_ar_ready}, 3'b011);
        cyc();
        rst = 0;

        // single read, minimum latency
        ar_addr = 48'h40; ar_len = 3; ar_valid = 1;
        exp0.push_back(mk(0, 20'h2, 6'd3));
        cyc();
        ar_valid = 0;
        @(negedge clk);
        chk("ar valid at N+1", tv, 0);
        chk("ar usage at N+1", ar_use, 1);
        cyc();
        trx_ready = 1;
        @(negedge clk);
        chk("ar valid at N+2", tv, 1);
        cyc();
        trx_ready = 0;
        @(negedge clk);
        chk("ar done valid", tv, 0);
        chk("ar done usage", ar_use, 0);
        chk("ar done fields", {tw, ta, tl}, 0);

        // write gated on credit
        cyc();
        aw_addr = 48'h1000; aw_len = 7; aw_valid = 1;
        exp0.push_back(mk(1, 20'h80, 6'd7));
        cyc();
        aw_valid = 0;
        cyc(2);
        @(negedge clk);
        chk("w no credit valid", tv, 0);
        for (int i = 0; i < 8; i++) begin
            cyc();
            w_push = 1;
            @(negedge clk);
            chk("w short credit valid", tv, 0);
        end
        cyc();
        w_push = 0;
        trx_ready = 1;
        @(negedge clk);
        chk("w full credit valid", tv, 1);
        chk("w credit before hs", credit, 8);
        cyc();
        trx_ready = 0;
        @(negedge clk);
        chk("w credit after hs", credit, 0);
        chk("w done valid", tv, 0);

        // 200-beat read split into 64/64/64/8
        cyc();
        trx_ready = 1;
        ar_addr = 48'h20000; ar_len = 199; ar_valid = 1;
        exp0.push_back(mk(0, 20'h01000, 6'd63));
        exp0.push_back(mk(0, 20'h01040, 6'd63));
        exp0.push_back(mk(0, 20'h01080, 6'd63));
        exp0.push_back(mk(0, 20'h010C0, 6'd7));
        cyc();
        ar_valid = 0;
        @(negedge clk);
        chk("burst load cycle valid", tv, 0);
        for (int i = 0; i < 4; i++) begin
            cyc();
            @(negedge clk);
            chk("burst back-to-back valid", tv, 1);
        end
        cyc();
        @(negedge clk);
        chk("burst bubble valid", tv, 0);

        // high address bits dropped, chunk address wraps
        ar_addr = 48'h0100_01FF_F800; ar_len = 127; ar_valid = 1;
        exp0.push_back(mk(0, 20'hFFFC0, 6'd63));
        exp0.push_back(mk(0, 20'h00000, 6'd63));
        cyc();
        ar_valid = 0;
        drain0(12);
        trx_ready = 0;

        // round-robin W R W R W R
        do_reset();
        for (int i = 0; i < 3; i++) begin
            w_push = 1;
            cyc();
        end
        w_push = 0;
        for (int k = 0; k < 3; k++) begin
            aw_addr = 48'(k) * 48'h100; aw_len = 0; aw_valid = 1;
            ar_addr = 48'h2000 + 48'(k) * 48'h20; ar_len = 1; ar_valid = 1;
            exp0.push_back(mk(1, 20'(8 * k), 6'd0));
            exp0.push_back(mk(0, 20'(32'h100 + k), 6'd1));
            cyc();
        end
        aw_valid = 0;
        ar_valid = 0;
        @(negedge clk);
        chk("rr aw usage", aw_use, 2);
        chk("rr ar usage", ar_use, 3);
        chk("rr credit", credit, 3);
        cyc();
        trx_ready = 1;
        drain0(40);
        chk("rr final credit", credit, 0);
        trx_ready = 0;

        // full AW FIFO, pop+push when full, reset mid-issue
        do_reset();
        for (int k = 0; k < 5; k++) begin
            aw_addr = 48'h4000 + 48'(k) * 48'h20; aw_len = 0; aw_valid = 1;
            cyc();
        end
        aw_valid = 0;
        exp0.push_back(mk(1, 20'h200, 6'd0));
        @(negedge clk);
        chk("full aw usage", aw_use, 4);
        chk("full aw_ready", aw_ready, 0);
        chk("full no credit valid", tv, 0);
        cyc();
        w_push = 1;
        trx_ready = 1;
        cyc();
        w_push = 0;
        @(negedge clk);
        chk("full first write valid", tv, 1);
        cyc();
        trx_ready = 0;
        aw_addr = 48'h40A0; aw_valid = 1;
        @(negedge clk);
        chk("full pop cycle aw_ready", aw_ready, 1);
        chk("full pop cycle usage", aw_use, 4);
        cyc();
        aw_valid = 0;
        w_push = 1;
        @(negedge clk);
        chk("full after pop+push usage", aw_use, 4);
        chk("full after pop+push ready", aw_ready, 0);
        cyc();
        w_push = 0;
        @(negedge clk);
        chk("mid-issue valid", tv, 1);
        chk("mid-issue credit", credit, 1);
        rst = 1;
        #1;
        chk("async rst valid", tv, 0);
        chk("async rst usage", aw_use, 0);
        chk("async rst credit", credit, 0);
        chk("async rst aw_ready", aw_ready, 1);
        cyc();
        rst = 0;
        chk("dut0 queue empty", exp0.size(), 0);

        // read priority with starvation guard: R R W R R
        cyc();
        b_w_push = 1;
        cyc();
        b_w_push = 0;
        for (int k = 0; k < 4; k++) begin
            b_ar_addr = 48'(k + 1) * 48'h20; b_ar_len = 2; b_ar_valid = 1;
            b_aw_addr = 48'h8000; b_aw_len = 0; b_aw_valid = (k == 0);
            cyc();
        end
        b_ar_valid = 0;
        b_aw_valid = 0;
        exp1.push_back(mk(0, 20'h1, 6'd2));
        exp1.push_back(mk(0, 20'h2, 6'd2));
        exp1.push_back(mk(1, 20'h400, 6'd0));
        exp1.push_back(mk(0, 20'h3, 6'd2));
        exp1.push_back(mk(0, 20'h4, 6'd2));
        @(negedge clk);
        chk("prio ar usage", b_ar_use, 3);
        cyc();
        b_trx_ready = 1;
        drain1(40);
        chk("prio final credit", b_credit, 0);
        b_trx_ready = 0;
        cyc(2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
